demux_router: RTL and testbench

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_router.sv | 93 +++++++++
 tb/tb_demux_router.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/demux_router.sv
// One-entry-per-channel 1:4 demultiplexer with valid/ready handshakes on every side.
// Optional per-channel input-transfer counters are enabled by defining DEMUX_ROUTER_CNT_EN.
module demux_router #(
  parameter int DATA_W = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        direction_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data0_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] data3_o,
  output logic              valid0_o,
  output logic              valid1_o,
  output logic              valid2_o,
  output logic              valid3_o,
  input  logic              ready0_i,
  input  logic              ready1_i,
  input  logic              ready2_i,
  input  logic              ready3_i
`ifdef DEMUX_ROUTER_CNT_EN
  ,
  output logic [7:0]        cnt0_o,
  output logic [7:0]        cnt1_o,
  output logic [7:0]        cnt2_o,
  output logic [7:0]        cnt3_o
`endif
);

  logic [3:0]        valid_q, valid_d;
  logic [DATA_W-1:0] data_q [4];
  logic [DATA_W-1:0] data_d [4];
  logic [3:0]        rdy;
  logic              in_xfer;

  assign rdy     = {ready3_i, ready2_i, ready1_i, ready0_i};
  // A full channel still accepts when its sink drains it in the same cycle.
  assign ready_o = !valid_q[direction_i] || rdy[direction_i];
  assign in_xfer = valid_i && ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < 4; k++) begin
      if (valid_q[k] && rdy[k]) valid_d[k] = 1'b0;
      if (in_xfer && (direction_i == k[1:0])) begin
        valid_d[k] = 1'b1;
        data_d[k]  = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < 4; k++) data_q[k] <= data_d[k];
    end
  end

  assign data0_o  = data_q[0];
  assign data1_o  = data_q[1];
  assign data2_o  = data_q[2];
  assign data3_o  = data_q[3];
  assign valid0_o = valid_q[0];
  assign valid1_o = valid_q[1];
  assign valid2_o = valid_q[2];
  assign valid3_o = valid_q[3];

`ifdef DEMUX_ROUTER_CNT_EN
  logic [7:0] cnt_q [4];

  // Counters wrap naturally at 8 bits.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else if (in_xfer) begin
      cnt_q[direction_i] <= cnt_q[direction_i] + 8'd1;
    end
  end

  assign cnt0_o = cnt_q[0];
  assign cnt1_o = cnt_q[1];
  assign cnt2_o = cnt_q[2];
  assign cnt3_o = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_router.sv
// Scoreboard bench for demux_router: stimulus pushes expected payloads per channel,
// a negedge monitor pops and compares on every output transfer.
module tb_demux_router;
  localparam int DATA_W = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [DATA_W-1:0] data_i;
  logic [1:0]        direction_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] d0, d1, d2, d3;
  logic              v0, v1, v2, v3;
  logic              r0, r1, r2, r3;
`ifdef DEMUX_ROUTER_CNT_EN
  logic [7:0]        c0, c1, c2, c3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  demux_router #(.DATA_W(DATA_W)) dut (
    .clk_i(clk), .rstn_i(rstn), .data_i(data_i), .direction_i(direction_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .data0_o(d0), .data1_o(d1), .data2_o(d2), .data3_o(d3),
    .valid0_o(v0), .valid1_o(v1), .valid2_o(v2), .valid3_o(v3),
    .ready0_i(r0), .ready1_i(r1), .ready2_i(r2), .ready3_i(r3)
`ifdef DEMUX_ROUTER_CNT_EN
    , .cnt0_o(c0), .cnt1_o(c1), .cnt2_o(c2), .cnt3_o(c3)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [DATA_W-1:0] d);
    case (ch)
      2'd0: q0.push_back(d);
      2'd1: q1.push_back(d);
      2'd2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic mon_ch(input int ch, input logic v, input logic r, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] e;
    int sz;
    if (v && r) begin
      case (ch)
        0: sz = q0.size();
        1: sz = q1.size();
        2: sz = q2.size();
        default: sz = q3.size();
      endcase
      if (sz == 0) begin
        chk($sformatf("unexpected_out_ch%0d", ch), 32'(d), 32'hFFFF_FFFF);
      end else begin
        case (ch)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          2: e = q2.pop_front();
          default: e = q3.pop_front();
        endcase
        chk($sformatf("out_data_ch%0d", ch), 32'(d), 32'(e));
      end
    end
  endtask

  // Output transfers happen at the next posedge when valid && ready are both high here.
  always @(negedge clk) begin
    if (rstn) begin
      mon_ch(0, v0, r0, d0);
      mon_ch(1, v1, r1, d1);
      mon_ch(2, v2, r2, d2);
      mon_ch(3, v3, r3, d3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DATA_W-1:0] d, input logic [1:0] dir, input bit exp_push);
    data_i      = d;
    direction_i = dir;
    valid_i     = 1'b1;
    if (exp_push) push(dir, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; data_i = '0; direction_i = '0; valid_i = 1'b0;
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
    #2;
    chk("reset_valids", {28'd0, v3, v2, v1, v0}, 32'h0);
    chk("reset_data", {24'd0, d3, d2, d1, d0}, 32'h0);
    chk("reset_ready_o", 32'(ready_o), 32'h1);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    // Routing: first transfer on the first edge after reset release.
    drive(2'b11, 2'd0, 1'b1); #1 chk("route_ready0", 32'(ready_o), 32'h1); tick();
    chk("route_v0", 32'(v0), 32'h1); chk("route_d0", 32'(d0), 32'h3);
    drive(2'b10, 2'd1, 1'b1); tick();
    chk("route_d1", 32'(d1), 32'h2); chk("route_v0_pulse", 32'(v0), 32'h0);
    drive(2'b01, 2'd2, 1'b1); tick();
    chk("route_d2", 32'(d2), 32'h1); chk("route_v1_pulse", 32'(v1), 32'h0);
    drive(2'b00, 2'd3, 1'b1); tick();
    valid_i = 1'b0;
    chk("route_v3", 32'(v3), 32'h1); chk("route_v2_pulse", 32'(v2), 32'h0);
    tick();
    chk("route_all_empty", {28'd0, v3, v2, v1, v0}, 32'h0);

    // Idle input must not disturb held payloads.
    data_i = 2'b00; direction_i = 2'd0; valid_i = 1'b0; tick();
    chk("idle_hold_d0", 32'(d0), 32'h3);

    // Backpressure on channel 2, with channel 0 still flowing.
    r2 = 1'b0;
    drive(2'b01, 2'd2, 1'b1); #1 chk("bp_ready_first", 32'(ready_o), 32'h1); tick();
    drive(2'b10, 2'd2, 1'b0); #1 chk("bp_ready_second", 32'(ready_o), 32'h0); tick();
    chk("bp_hold_d2", 32'(d2), 32'h1); chk("bp_hold_v2", 32'(v2), 32'h1);
    drive(2'b11, 2'd0, 1'b1); #1 chk("hol_ready", 32'(ready_o), 32'h1); tick();
    chk("hol_d0", 32'(d0), 32'h3); chk("hol_v0", 32'(v0), 32'h1);
    chk("hol_still_d2", 32'(d2), 32'h1);
    drive(2'b10, 2'd2, 1'b1); #1 chk("bp_blocked", 32'(ready_o), 32'h0);
    r2 = 1'b1; #1 chk("bp_released", 32'(ready_o), 32'h1); tick();
    valid_i = 1'b0;
    chk("bp_new_d2", 32'(d2), 32'h2); chk("bp_new_v2", 32'(v2), 32'h1);
    tick();
    chk("bp_drained_v2", 32'(v2), 32'h0);

    // Simultaneous drain and refill on channel 1.
    r1 = 1'b0;
    drive(2'b10, 2'd1, 1'b1); tick();
    valid_i = 1'b0; #1;
    chk("sim_full_v1", 32'(v1), 32'h1);
    r1 = 1'b1;
    drive(2'b01, 2'd1, 1'b1); #1 chk("sim_ready", 32'(ready_o), 32'h1); tick();
    valid_i = 1'b0;
    chk("sim_v1", 32'(v1), 32'h1); chk("sim_d1", 32'(d1), 32'h1);
    tick();

    // Asynchronous reset mid-cycle with every channel full and stalled.
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
    drive(2'b11, 2'd0, 1'b0); tick();
    drive(2'b10, 2'd1, 1'b0); tick();
    drive(2'b01, 2'd2, 1'b0); tick();
    drive(2'b11, 2'd3, 1'b0); tick();
    valid_i = 1'b0; #1;
    chk("full_valids", {28'd0, v3, v2, v1, v0}, 32'hF);
    chk("full_ready_o", 32'(ready_o), 32'h0);
    #1 rstn = 1'b0; #1;
    chk("arst_valids", {28'd0, v3, v2, v1, v0}, 32'h0);
    chk("arst_data", {24'd0, d3, d2, d1, d0}, 32'h0);
    chk("arst_ready_o", 32'(ready_o), 32'h1);
    #1 rstn = 1'b1;
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
    tick();
    chk("post_rst_valids", {28'd0, v3, v2, v1, v0}, 32'h0);

`ifdef DEMUX_ROUTER_CNT_EN
    for (int i = 0; i < 257; i++) begin
      drive(DATA_W'(i), 2'd3, 1'b1); tick();
    end
    valid_i = 1'b0; tick();
    chk("cnt3", 32'(c3), 32'h1);
    chk("cnt_others", {8'd0, c2, c1, c0}, 32'h0);
`endif

    drive(2'b10, 2'd3, 1'b1); tick();
    valid_i = 1'b0;
    chk("after_rst_d3", 32'(d3), 32'h2);
    tick(); tick();
    chk("sb_empty", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
